// File: rtl/incline_pkg.sv
// Shared types and constants for the incline filter path.
package incline_pkg;

    localparam int RAW_W     = 16;
    localparam int INCL_W    = 13;
    localparam int OUT_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/incline_offset_cal.sv
// Offset calibration: averages the first 2^CAL_LOG2 samples and subtracts the
// result, with 16-bit saturation, from every later sample.
module incline_offset_cal
    import incline_pkg::*;
#(
    parameter int CAL_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_cal_en,
    input  logic [RAW_W-1:0] i_raw,
    output logic [RAW_W-1:0] o_sample,
    output logic             o_cal_last,
    output logic             o_cal_done
);

    localparam int SUM_W = RAW_W + CAL_LOG2;
    localparam int CNT_W = CAL_LOG2 + 1;
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);

    logic signed [SUM_W-1:0] r_sum;
    logic        [CNT_W-1:0] r_cnt;
    logic        [RAW_W-1:0] r_offset;
    logic                    r_done;
    logic signed [SUM_W-1:0] w_sum_nxt;
    logic signed [RAW_W:0]   w_diff;

    assign w_sum_nxt  = r_sum + {{CAL_LOG2{i_raw[RAW_W-1]}}, i_raw};
    assign o_cal_last = (r_cnt == CAL_LAST);
    assign o_cal_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_cnt    <= '0;
            r_offset <= '0;
            r_done   <= 1'b0;
        end else if (i_clr) begin
            r_sum    <= '0;
            r_cnt    <= '0;
            r_offset <= '0;
            r_done   <= 1'b0;
        end else if (i_cal_en) begin
            r_sum <= w_sum_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_cal_last) begin
                r_offset <= w_sum_nxt[SUM_W-1:CAL_LOG2];
                r_done   <= 1'b1;
            end
        end
    end

    // 17-bit difference; top two bits disagreeing means it left 16-bit range
    assign w_diff = {i_raw[RAW_W-1], i_raw} - {r_offset[RAW_W-1], r_offset};

    always_comb begin
        o_sample = w_diff[RAW_W-1:0];
        if (w_diff[RAW_W] != w_diff[RAW_W-1])
            o_sample = w_diff[RAW_W] ? {1'b1, {(RAW_W-1){1'b0}}} : {1'b0, {(RAW_W-1){1'b1}}};
    end

endmodule

// File: rtl/incline_filter.sv
// EMA filter (alpha = 1/2^SHIFT) producing the 13-bit incline word with a
// settled flag. Offset calibration is built only with INCLINE_OFFSET_CAL_EN.
module incline_filter
    import incline_pkg::*;
#(
    parameter int SHIFT    = 4,
    parameter int SETTLE   = 32,
    parameter int CAL_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              vld,
    input  logic [RAW_W-1:0]  incline_raw,
    output logic [INCL_W-1:0] incline,
    output logic              incline_vld,
    output logic              settled,
    output logic              cal_busy
);

    localparam int ACC_W = RAW_W + SHIFT;
    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t                   r_state, w_state_nxt;
    logic signed [ACC_W-1:0]  r_accum, w_accum_nxt;
    logic signed [ACC_W-1:0]  w_sample_ext;
    logic        [7:0]        r_cnt;
    logic                     r_settled, r_incline_vld;
    logic        [INCL_W-1:0] r_incline;
    logic        [RAW_W-1:0]  w_sample;
    logic                     w_go, w_prime, w_update, w_cal_en, w_cal_done, w_cal_last;

    assign w_go     = vld & ~clr;
    assign w_prime  = w_go & (r_state == IDLE) & w_cal_done;
    assign w_update = w_go & (r_state == RUN);
    assign w_cal_en = w_go & (((r_state == IDLE) & ~w_cal_done) | (r_state == CAL));

`ifdef INCLINE_OFFSET_CAL_EN
    incline_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (clr),
        .i_cal_en   (w_cal_en),
        .i_raw      (incline_raw),
        .o_sample   (w_sample),
        .o_cal_last (w_cal_last),
        .o_cal_done (w_cal_done)
    );
    assign cal_busy = (r_state == CAL);
`else
    logic w_unused_cal;
    assign w_sample     = incline_raw;
    assign w_cal_done   = 1'b1;
    assign w_cal_last   = 1'b0;
    assign cal_busy     = 1'b0;
    assign w_unused_cal = (CAL_LOG2 != 0) | w_cal_en;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = IDLE;
        end else if (vld) begin
            case (r_state)
                IDLE:    if (w_cal_done) w_state_nxt = RUN;
                         else if (!w_cal_last) w_state_nxt = CAL;
                CAL:     if (w_cal_last) w_state_nxt = IDLE;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_sample_ext = {{SHIFT{w_sample[RAW_W-1]}}, w_sample};

    always_comb begin
        w_accum_nxt = r_accum;
        if (w_prime)
            w_accum_nxt = {w_sample, {SHIFT{1'b0}}};
        else if (w_update)
            w_accum_nxt = r_accum + w_sample_ext - (r_accum >>> SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accum       <= '0;
            r_incline     <= '0;
            r_incline_vld <= 1'b0;
            r_cnt         <= '0;
            r_settled     <= 1'b0;
        end else begin
            r_accum       <= w_accum_nxt;
            r_incline_vld <= w_prime | w_update;
            // incline = (accum >>> SHIFT) >>> OUT_SHIFT, i.e. the top INCL_W bits
            if (w_prime | w_update)
                r_incline <= w_accum_nxt[ACC_W-1 -: INCL_W];
            if (clr) begin
                r_cnt     <= '0;
                r_settled <= 1'b0;
            end else if (w_update) begin
                if (r_cnt != SETTLE_C) r_cnt <= r_cnt + 8'd1;
                if (r_cnt >= SETTLE_M1) r_settled <= 1'b1;
            end
        end
    end

    assign incline     = r_incline;
    assign incline_vld = r_incline_vld;
    assign settled     = r_settled;

endmodule

// File: tb/tb_incline_filter.sv
// Directed self-checking bench for incline_filter (SHIFT=4, SETTLE=32, CAL_LOG2=4).
module tb_incline_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] incline_raw = '0;
    logic [12:0] incline;
    logic        incline_vld, settled, cal_busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    incline_filter #(.SHIFT(4), .SETTLE(32), .CAL_LOG2(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .vld         (vld),
        .incline_raw (incline_raw),
        .incline     (incline),
        .incline_vld (incline_vld),
        .settled     (settled),
        .cal_busy    (cal_busy)
    );

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [12:0] e0;
        logic [12:0] e1;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic cyc(input logic v, input logic [15:0] r, input logic c);
        vld = v;
        incline_raw = r;
        clr = c;
        @(posedge clk);
        #1;
        vld = 1'b0;
        clr = 1'b0;
    endtask

    // Return to IDLE; with calibration built, calibrate to a zero offset.
    task automatic prep();
        cyc(1'b0, 16'h0, 1'b1);
`ifdef INCLINE_OFFSET_CAL_EN
        for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0, 1'b0);
`endif
    endtask

    initial begin
        tbl[0] = '{16'h0800, 16'h0800, 13'h0100, 13'h0100};
        tbl[1] = '{16'h0000, 16'd1600, 13'h0000, 13'd12};
        tbl[2] = '{16'hFFF8, 16'hFFF8, 13'h1FFF, 13'h1FFF};
        tbl[3] = '{16'h7FFF, 16'h8000, 13'h0FFF, 13'h0DFF};
        tbl[4] = '{16'h8000, 16'h7FFF, 13'h1000, 13'h11FF};

        #12;
        chk("rst_incline", 32'(incline), 32'h0);
        chk("rst_vld", 32'(incline_vld), 32'h0);
        chk("rst_settled", 32'(settled), 32'h0);
        chk("rst_cal_busy", 32'(cal_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1'b0, 16'h0, 1'b1);
        chk("idle_clr_noop_vld", 32'(incline_vld), 32'h0);

        for (int i = 0; i < 5; i++) begin
            prep();
            cyc(1'b1, tbl[i].r0, 1'b0);
            chk($sformatf("prime_vld[%0d]", i), 32'(incline_vld), 32'h1);
            chk($sformatf("prime_incl[%0d]", i), 32'(incline), 32'(tbl[i].e0));
            chk($sformatf("prime_settled[%0d]", i), 32'(settled), 32'h0);
            cyc(1'b1, tbl[i].r1, 1'b0);
            chk($sformatf("upd_vld[%0d]", i), 32'(incline_vld), 32'h1);
            chk($sformatf("upd_incl[%0d]", i), 32'(incline), 32'(tbl[i].e1));
            cyc(1'b0, 16'h0, 1'b0);
            chk($sformatf("hold_vld[%0d]", i), 32'(incline_vld), 32'h0);
            chk($sformatf("hold_incl[%0d]", i), 32'(incline), 32'(tbl[i].e1));
        end

        // Back-to-back samples: settled rises with the 32nd post-prime pulse
        prep();
        for (int i = 0; i < 33; i++) begin
            cyc(1'b1, 16'h0400, 1'b0);
            chk($sformatf("b2b_vld[%0d]", i), 32'(incline_vld), 32'h1);
            chk($sformatf("b2b_incl[%0d]", i), 32'(incline), 32'h80);
            chk($sformatf("b2b_settled[%0d]", i), 32'(settled), (i >= 32) ? 32'h1 : 32'h0);
        end
        cyc(1'b0, 16'h0, 1'b0);
        chk("b2b_end_vld", 32'(incline_vld), 32'h0);
        chk("b2b_end_settled", 32'(settled), 32'h1);

        // clr with vld mid-RUN: sample dropped, settled cleared, incline held
        cyc(1'b1, 16'h1000, 1'b1);
        chk("clrvld_vld", 32'(incline_vld), 32'h0);
        chk("clrvld_settled", 32'(settled), 32'h0);
        chk("clrvld_incl", 32'(incline), 32'h80);
`ifdef INCLINE_OFFSET_CAL_EN
        for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0, 1'b0);
`endif
        cyc(1'b1, 16'h1000, 1'b0);
        chk("reprime_vld", 32'(incline_vld), 32'h1);
        chk("reprime_incl", 32'(incline), 32'h200);
        cyc(1'b1, 16'h1000, 1'b0);
        chk("reprime_settled", 32'(settled), 32'h0);

`ifdef INCLINE_OFFSET_CAL_EN
        cyc(1'b0, 16'h0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 16'd400, 1'b0);
            chk($sformatf("cal_busy[%0d]", k), 32'(cal_busy), (k < 16) ? 32'h1 : 32'h0);
            chk($sformatf("cal_novld[%0d]", k), 32'(incline_vld), 32'h0);
        end
        cyc(1'b1, 16'd400, 1'b0);
        chk("cal_prime_vld", 32'(incline_vld), 32'h1);
        chk("cal_prime_incl", 32'(incline), 32'h0);
        cyc(1'b1, 16'h8000, 1'b0);
        chk("cal_sat_incl", 32'(incline), 32'h1F00);
`endif

        // Asynchronous reset mid-operation
        cyc(1'b1, 16'h2000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_incl", 32'(incline), 32'h0);
        chk("async_vld", 32'(incline_vld), 32'h0);
        chk("async_settled", 32'(settled), 32'h0);
        chk("async_cal_busy", 32'(cal_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef INCLINE_OFFSET_CAL_EN
        for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0, 1'b0);
`endif
        cyc(1'b1, 16'h0800, 1'b0);
        chk("post_rst_prime", 32'(incline), 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/incline_filter.md
Name: incline_filter

Overview:
- Upstream stage of the desiredDrive incline path.
- Takes raw signed 16-bit pitch/incline samples from the inertial interface, each qualified by a valid strobe.
- Applies a first-order exponential moving average (alpha = 1/2^SHIFT).
- Rescales the result to the signed 13-bit incline word that the incline saturation stage consumes.
- Provides a per-sample output strobe and a settled flag, so desiredDrive ignores incline until the filter has converged.

Parameters:
SHIFT, 4, filter time constant; alpha = 1/2^SHIFT; legal range 1..8
SETTLE, 32, number of accepted samples after priming before settled asserts; legal range 1..255
CAL_LOG2, 4, log2 of the sample count averaged for the offset (used only with INCLINE_OFFSET_CAL_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; returns filter to IDLE
vld  input  1  single-cycle strobe; incline_raw valid this cycle
incline_raw  input  16  signed raw incline sample
incline  output  13  signed filtered incline, feeds incline saturation stage
incline_vld  output  1  one-cycle pulse; incline updated this cycle
settled  output  1  high once SETTLE samples are filtered after priming
cal_busy  output  1  high during offset calibration; constant 0 without the macro

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; accumulator = 0; settle counter = 0.
  - incline = 0, incline_vld = 0, settled = 0, cal_busy = 0.
- States: IDLE -> (CAL, only with the macro) -> RUN.
  - IDLE: the first vld primes the filter. The accumulator loads the sample sign-extended and shifted left by SHIFT, so the average equals the sample. Next state is RUN.
  - RUN: each vld updates the accumulator as accum + sample - (accum >>> SHIFT).
- Accumulator:
  - Signed, 16+SHIFT bits.
  - It is a convex combination, so it cannot overflow and needs no saturation.
- Output path:
  - avg = accum >>> SHIFT (16-bit signed).
  - incline = avg >>> 3 (bits [15:3]), arithmetic, i.e. truncation toward negative infinity.
- Latency:
  - incline and incline_vld are registered.
  - For a vld in cycle N, incline_vld pulses in cycle N+1 with the updated incline.
  - incline holds its value between pulses.
- Back-to-back vld (every cycle):
  - Every sample is processed.
  - incline_vld stays high continuously, one update per cycle.
- Settle counter:
  - Increments on each RUN-state vld and saturates at SETTLE.
  - settled is registered and asserts in the same cycle as the incline_vld for the SETTLE-th post-prime sample.
  - settled stays high until clr or reset.
- clr:
  - Next cycle: state = IDLE, counter = 0, settled = 0, incline_vld = 0.
  - incline holds its last value until the next prime.
  - If clr and vld arrive in the same cycle, clr wins and the sample is dropped.
  - clr with no vld in IDLE is a no-op.
- Mid-operation async reset behaves exactly like power-on reset.

Optional Feature:
- Macro: INCLINE_OFFSET_CAL_EN.
- When defined:
  - The first vld after reset or clr starts calibration: state goes IDLE -> CAL and cal_busy = 1.
  - CAL sums 2^CAL_LOG2 samples, including that first one.
  - offset = sum >>> CAL_LOG2 (16-bit signed). This offset is held until reset or clr.
  - After calibration, state returns to a prime-pending substate. The next vld primes the filter and goes to RUN.
  - cal_busy drops the cycle after the last calibration sample.
  - In all later states each sample becomes incline_raw - offset, saturated to 16-bit signed (0x7FFF / 0x8000), before filtering.
  - No incline_vld pulses during CAL.
- When undefined:
  - No CAL state and no offset register.
  - Samples feed the filter directly.
  - cal_busy is tied to 0.

Decomposition:
- Shared package incline_pkg contains:
  - the state enum (IDLE, CAL, RUN);
  - RAW_W = 16 and INCL_W = 13;
  - the output scale shift constant, 3.
- Natural sub-module: incline_offset_cal. It owns the calibration sum, sample counter and offset register, and the subtract/saturate logic.
  - It is instantiated only under INCLINE_OFFSET_CAL_EN.
  - The top level holds the FSM, accumulator and settle counter.

Test Plan (SHIFT=4, SETTLE=32, CAL_LOG2=4):
- Prime with 16'h0800 -> next cycle incline_vld=1, incline=13'h0100, settled=0.
- Prime with 0, then 16'd1600 -> second incline_vld shows avg=100, incline=13'd12.
- Prime with 16'hFFF8 (-8) -> incline=13'h1FFF (-1), checking arithmetic truncation.
- 33 consecutive vld cycles of 16'h0400 -> incline_vld high every cycle after the first; settled rises on the pulse for the 33rd sample (32nd post-prime).
- clr asserted together with vld mid-RUN -> sample dropped, no incline_vld, settled=0; next vld re-primes.
- With INCLINE_OFFSET_CAL_EN: 16 samples of 16'd400 (cal_busy=1, no incline_vld), then sample 400 -> incline=0. Then sample 16'h8000 -> -32768-400 saturates to 16'h8000 before filtering.
